// File: rtl/ram_arbiter_if.sv
// Request, wait/load and RAM-port signals shared between the cores, the RAM model and ram_arbiter.
// The arbiter connects through the slave modport, and the cores and RAM side connect through the master modport.
interface ram_arbiter_if #(
    parameter int CPUS = 2
);
    logic [CPUS-1:0]       iREN;
    logic [CPUS-1:0][31:0] iaddr;
    logic [CPUS-1:0]       dREN;
    logic [CPUS-1:0]       dWEN;
    logic [CPUS-1:0][31:0] daddr;
    logic [CPUS-1:0][31:0] dstore;
    logic [CPUS-1:0]       iwait;
    logic [CPUS-1:0]       dwait;
    logic [CPUS-1:0][31:0] iload;
    logic [CPUS-1:0][31:0] dload;
    logic                  ramREN;
    logic                  ramWEN;
    logic [31:0]           ramaddr;
    logic [31:0]           ramstore;
    logic [31:0]           ramload;
    logic [1:0]            ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter shares a single RAM port between CPUS cores. Data requests have priority over instruction requests.
// Within each class the cores are served round-robin, and a starvation counter forces an instruction grant after STARVE_LIMIT data grants.
module ram_arbiter #(
    parameter int CPUS         = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic         CLK,
    input logic         nRST,
    ram_arbiter_if.slave bus
);
    localparam int         IW         = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [3:0] LIMIT      = 4'(STARVE_LIMIT);

    typedef enum logic {IDLE, SERVE} state_t;

    state_t          state, next_state;
    logic            grant_d, next_grant_d;
    logic [IW-1:0]   grant_core, next_grant_core;
    logic [IW-1:0]   i_ptr, next_i_ptr;
    logic [IW-1:0]   d_ptr, next_d_ptr;
    logic [3:0]      starve_cnt, next_starve_cnt;

    logic [CPUS-1:0] dreq;
    logic            any_i, any_d, pick_d, live, done;

    // Return the first requesting core at or after ptr, wrapping modulo CPUS.
    function automatic logic [IW-1:0] rr_pick(input logic [CPUS-1:0] req, input logic [IW-1:0] ptr);
        logic          found;
        logic [IW-1:0] idx;
        rr_pick = ptr;
        found   = 1'b0;
        for (int k = 0; k < CPUS; k++) begin
            idx = IW'((int'(ptr) + k) % CPUS);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
        wrap_inc = (v == IW'(CPUS - 1)) ? '0 : v + 1'b1;
    endfunction

    always_comb begin
        dreq   = bus.dREN | bus.dWEN;
        any_i  = |bus.iREN;
        any_d  = |dreq;
        pick_d = any_d && !((starve_cnt == LIMIT) && any_i);
        live   = grant_d ? dreq[grant_core] : bus.iREN[grant_core];
        done   = (state == SERVE) && live && (bus.ramstate == RAM_ACCESS);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            grant_d    <= 1'b0;
            grant_core <= '0;
            i_ptr      <= '0;
            d_ptr      <= '0;
            starve_cnt <= '0;
        end else begin
            state      <= next_state;
            grant_d    <= next_grant_d;
            grant_core <= next_grant_core;
            i_ptr      <= next_i_ptr;
            d_ptr      <= next_d_ptr;
            starve_cnt <= next_starve_cnt;
        end
    end

    // NOTE: every output and next-value gets a default first, so no path through the case infers a latch.
    always_comb begin
        next_state      = state;
        next_grant_d    = grant_d;
        next_grant_core = grant_core;
        next_i_ptr      = i_ptr;
        next_d_ptr      = d_ptr;
        next_starve_cnt = starve_cnt;
        bus.ramREN      = 1'b0;
        bus.ramWEN      = 1'b0;
        bus.ramaddr     = '0;
        bus.ramstore    = '0;
        bus.iwait       = bus.iREN;
        bus.dwait       = dreq;
        bus.iload       = '0;
        bus.dload       = '0;

        case (state)
            IDLE: begin
                if (any_d || any_i) begin
                    next_state      = SERVE;
                    next_grant_d    = pick_d;
                    next_grant_core = pick_d ? rr_pick(dreq, d_ptr) : rr_pick(bus.iREN, i_ptr);
                end
            end
            SERVE: begin
                // A withdrawn request aborts the grant and leaves the pointers and counters untouched.
                if (!live) begin
                    next_state = IDLE;
                end else begin
                    if (grant_d) begin
                        bus.ramWEN   = bus.dWEN[grant_core];
                        bus.ramREN   = bus.dREN[grant_core] & ~bus.dWEN[grant_core];
                        bus.ramaddr  = bus.daddr[grant_core];
                        bus.ramstore = bus.dstore[grant_core];
                    end else begin
                        bus.ramREN  = 1'b1;
                        bus.ramaddr = bus.iaddr[grant_core];
                    end
                    if (done) begin
                        next_state = IDLE;
                        if (grant_d) begin
                            bus.dwait[grant_core] = 1'b0;
                            bus.dload[grant_core] = bus.ramload;
                            next_d_ptr            = wrap_inc(grant_core);
                            if (!any_i)
                                next_starve_cnt = '0;
                            else if (starve_cnt != LIMIT)
                                next_starve_cnt = starve_cnt + 4'd1;
                        end else begin
                            bus.iwait[grant_core] = 1'b0;
                            bus.iload[grant_core] = bus.ramload;
                            next_i_ptr            = wrap_inc(grant_core);
                            next_starve_cnt       = '0;
                        end
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter. A random and directed stimulus driver predicts each grant from the arbitration rules and queues it.
// A RAM model and a completion monitor check each completion against the queue and record the grant that was actually observed.
module tb_ram_arbiter;
    localparam int         CPUS   = 2;
    localparam int         LIMIT  = 4;
    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    logic CLK = 1'b0;
    logic nRST;

    ram_arbiter_if #(.CPUS(CPUS)) bus ();

    ram_arbiter #(.CPUS(CPUS), .STARVE_LIMIT(LIMIT)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.slave)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          is_d;
        int          core;
        logic [31:0] addr;
        bit          we;
        logic [31:0] store;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        bit is_d;
        int core;
    } grant_t;

    exp_t   q[$];
    grant_t glog[$];
    int     checks = 0;
    int     errors = 0;
    bit     idone[CPUS];
    bit     ddone[CPUS];
    bit     gap_pending = 1'b0;
    int     m_iptr, m_dptr, m_starve;
    int     mode = 0;
    int     busy_cfg = 0;
    int     i_issued = 0;
    int     q_age = 0;

    function automatic logic [31:0] ram_data(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    // RAM model: busy_cfg wait cycles before ACCESS, or a random 0..3 when busy_cfg is negative.
    initial begin
        int busy_left;
        busy_left    = -1;
        bus.ramstate = FREE;
        bus.ramload  = '0;
        forever begin
            @(posedge CLK);
            #2;
            if (!nRST || !(bus.ramREN || bus.ramWEN)) begin
                bus.ramstate = FREE;
                bus.ramload  = '0;
                busy_left    = -1;
            end else begin
                if (busy_left < 0)
                    busy_left = (busy_cfg < 0) ? int'($urandom_range(0, 3)) : busy_cfg;
                bus.ramload = ram_data(bus.ramaddr);
                if (busy_left > 0) begin
                    bus.ramstate = ($urandom_range(0, 3) == 0) ? FREE : BUSY;
                    busy_left--;
                end else begin
                    bus.ramstate = ACCESS;
                    busy_left    = -1;
                end
            end
        end
    end

    task automatic on_completion();
        exp_t                  e;
        grant_t                g;
        logic [CPUS-1:0]       gi, gd, dreq;
        logic [CPUS-1:0][31:0] ei, ed;
        string                 tag;
        dreq = bus.dREN | bus.dWEN;
        g.is_d = 1'b0;
        g.core = -1;
        for (int c = 0; c < CPUS; c++) begin
            if (bus.iREN[c] && !bus.iwait[c]) begin g.is_d = 1'b0; g.core = c; end
            if (dreq[c] && !bus.dwait[c])     begin g.is_d = 1'b1; g.core = c; end
        end
        glog.push_back(g);
        gap_pending = 1'b1;
        if (q.size() == 0) begin
            check("unexpected_completion", 64'(q.size()), 64'd1);
            return;
        end
        e   = q.pop_front();
        tag = $sformatf("%s%0d", e.is_d ? "d" : "i", e.core);
        gi = '0; gd = '0; ei = '0; ed = '0;
        if (e.is_d) begin
            gd[e.core] = 1'b1; ed[e.core] = e.data; ddone[e.core] = 1'b1;
        end else begin
            gi[e.core] = 1'b1; ei[e.core] = e.data; idone[e.core] = 1'b1;
        end
        check({tag, "_ramaddr"}, 64'(bus.ramaddr), 64'(e.addr));
        check({tag, "_ramWEN"},  64'(bus.ramWEN),  64'(e.we));
        check({tag, "_ramREN"},  64'(bus.ramREN),  64'(!e.we));
        if (e.we) check({tag, "_ramstore"}, 64'(bus.ramstore), 64'(e.store));
        check({tag, "_iwait"}, 64'(bus.iwait), 64'(bus.iREN & ~gi));
        check({tag, "_dwait"}, 64'(bus.dwait), 64'(dreq & ~gd));
        check({tag, "_iload"}, 64'(bus.iload), 64'(ei));
        check({tag, "_dload"}, 64'(bus.dload), 64'(ed));
    endtask

    always @(negedge CLK) begin
        if (!nRST) begin
            gap_pending = 1'b0;
        end else begin
            if (gap_pending) begin
                check("idle_gap_strobes", 64'({bus.ramREN, bus.ramWEN}), 64'd0);
                gap_pending = 1'b0;
            end
            if ((bus.ramREN || bus.ramWEN) && bus.ramstate == ACCESS)
                on_completion();
        end
    end

    task automatic new_i(input int c);
        bus.iREN[c]  = 1'b1;
        bus.iaddr[c] = $urandom & 32'hFFFF_FFFC;
    endtask

    task automatic new_d(input int c);
        int r;
        r = int'($urandom_range(0, 3));
        bus.dREN[c]   = (r != 1);
        bus.dWEN[c]   = (r == 1) || (r == 2);
        bus.daddr[c]  = $urandom & 32'hFFFF_FFFC;
        bus.dstore[c] = $urandom;
    endtask

    // Retire completed requests into the reference state, then apply the stimulus policy for this cycle.
    task automatic tick();
        bit any_i;
        @(posedge CLK);
        #1;
        q_age = (q.size() > 0) ? q_age + 1 : 0;
        if (q_age > 40) begin
            check("watchdog_q_age", 64'(q_age), 64'd0);
            finish_sim();
        end
        any_i = |bus.iREN;
        for (int c = 0; c < CPUS; c++) begin
            if (ddone[c]) begin
                ddone[c]    = 1'b0;
                m_dptr      = (c + 1) % CPUS;
                m_starve    = any_i ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
                bus.dREN[c] = 1'b0;
                bus.dWEN[c] = 1'b0;
            end
            if (idone[c]) begin
                idone[c]    = 1'b0;
                m_iptr      = (c + 1) % CPUS;
                m_starve    = 0;
                bus.iREN[c] = 1'b0;
            end
        end
        apply_policy();
    endtask

    task automatic apply_policy();
        for (int c = 0; c < CPUS; c++) begin
            case (mode)
                1: begin
                    if (!bus.iREN[c] && $urandom_range(0, 3) == 0) new_i(c);
                    if (!(bus.dREN[c] || bus.dWEN[c]) && $urandom_range(0, 3) == 0) new_d(c);
                end
                2: if (!(bus.dREN[c] || bus.dWEN[c])) new_d(c);
                3: if (!bus.iREN[c] && i_issued < 6) begin new_i(c); i_issued++; end
                default: ;
            endcase
        end
    endtask

    // The arbiter is idle whenever nothing is outstanding, so the prediction uses the request set it sees this cycle.
    task automatic predict();
        logic [CPUS-1:0] dreq, req;
        bit              use_d;
        int              ptr, win;
        exp_t            e;
        if (q.size() != 0) return;
        dreq = bus.dREN | bus.dWEN;
        if (!(|dreq) && !(|bus.iREN)) return;
        use_d = (|dreq) && !((m_starve == LIMIT) && (|bus.iREN));
        req   = use_d ? dreq : bus.iREN;
        ptr   = use_d ? m_dptr : m_iptr;
        win   = -1;
        for (int k = 0; k < CPUS; k++)
            if (win < 0 && req[(ptr + k) % CPUS]) win = (ptr + k) % CPUS;
        e.is_d  = use_d;
        e.core  = win;
        e.addr  = use_d ? bus.daddr[win] : bus.iaddr[win];
        e.we    = use_d && bus.dWEN[win];
        e.store = use_d ? bus.dstore[win] : 32'd0;
        e.data  = ram_data(e.addr);
        q.push_back(e);
    endtask

    task automatic step();
        tick();
        predict();
    endtask

    task automatic drain();
        mode = 0;
        for (int n = 0; n < 200; n++) begin
            if (q.size() == 0 && !(|{bus.iREN, bus.dREN, bus.dWEN})) break;
            step();
        end
        check("drain_pending", 64'({bus.iREN, bus.dREN, bus.dWEN}), 64'd0);
        check("drain_queue", 64'(q.size()), 64'd0);
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0;
        bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
        q.delete();
        glog.delete();
        for (int c = 0; c < CPUS; c++) begin idone[c] = 1'b0; ddone[c] = 1'b0; end
        m_iptr = 0; m_dptr = 0; m_starve = 0; mode = 0; q_age = 0;
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
    endtask

    initial begin
        int nd;
        bit seen_i;
        nRST = 1'b1;
        #1;
        nRST = 1'b0;
        bus.iREN = 2'b10; bus.dREN = 2'b01; bus.dWEN = 2'b10;
        bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
        #1;
        check("rst_iwait", 64'(bus.iwait), 64'(2'b10));
        check("rst_dwait", 64'(bus.dwait), 64'(2'b11));
        check("rst_strobes", 64'({bus.ramREN, bus.ramWEN}), 64'd0);
        check("rst_ramaddr", 64'(bus.ramaddr), 64'd0);
        check("rst_loads", 64'({bus.iload, bus.dload}), 64'd0);

        // Single instruction fetch held for two BUSY cycles.
        do_reset();
        busy_cfg = 2;
        tick();
        bus.iaddr[0] = 32'h40;
        bus.iREN[0]  = 1'b1;
        predict();
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge CLK);
            check($sformatf("lat_c%0d_ramREN", cyc), 64'(bus.ramREN), 64'(cyc >= 1));
            check($sformatf("lat_c%0d_ramaddr", cyc), 64'(bus.ramaddr), (cyc >= 1) ? 64'h40 : 64'd0);
            check($sformatf("lat_c%0d_iwait0", cyc), 64'(bus.iwait[0]), 64'(cyc < 3));
            if (cyc < 3) step();
        end
        drain();

        // A write from core0 and a read from core1 arrive together.
        do_reset();
        busy_cfg = 0;
        tick();
        bus.dWEN[0] = 1'b1; bus.daddr[0] = 32'h100; bus.dstore[0] = 32'hCAFE_0001;
        bus.dREN[1] = 1'b1; bus.daddr[1] = 32'h204;
        predict();
        drain();
        tick();
        bus.dREN = 2'b11; bus.daddr[0] = 32'h300; bus.daddr[1] = 32'h304;
        predict();
        drain();
        check("dd_grants", 64'(glog.size()), 64'd4);
        if (glog.size() >= 3) begin
            check("dd_g0", 64'({glog[0].is_d, 8'(glog[0].core)}), 64'({1'b1, 8'd0}));
            check("dd_g1", 64'({glog[1].is_d, 8'(glog[1].core)}), 64'({1'b1, 8'd1}));
            check("dd_ptr_back_to_0", 64'({glog[2].is_d, 8'(glog[2].core)}), 64'({1'b1, 8'd0}));
        end

        // Held core0 instruction fetch against a continuous stream of data requests.
        do_reset();
        busy_cfg = 0;
        tick();
        bus.iaddr[0] = 32'h800; bus.iREN[0] = 1'b1;
        mode = 2;
        apply_policy();
        predict();
        seen_i = 1'b0;
        for (int n = 0; n < 100 && !seen_i; n++) begin
            step();
            foreach (glog[k]) if (!glog[k].is_d) seen_i = 1'b1;
        end
        nd = 0;
        foreach (glog[k]) if (glog[k].is_d && !seen_i) nd++;
        if (seen_i) begin
            nd = 0;
            for (int k = 0; k < glog.size() && glog[k].is_d; k++) nd++;
            check("starve_i_core", 64'(glog[nd].core), 64'd0);
        end
        check("starve_i_seen", 64'(seen_i), 64'd1);
        check("starve_d_grants", 64'(nd), 64'(LIMIT));
        drain();

        // A data read is withdrawn while the RAM reports BUSY.
        do_reset();
        busy_cfg = 5;
        tick();
        bus.dREN[0] = 1'b1; bus.daddr[0] = 32'h500;
        predict();
        step();
        check("abort_pre_ramREN", 64'(bus.ramREN), 64'd1);
        tick();
        bus.dREN[0] = 1'b0;
        #1;
        check("abort_ramREN_drop", 64'(bus.ramREN), 64'd0);
        q.delete();
        tick();
        check("abort_idle_strobes", 64'({bus.ramREN, bus.ramWEN}), 64'd0);
        busy_cfg = 0;
        bus.dREN = 2'b11; bus.daddr[0] = 32'h600; bus.daddr[1] = 32'h604;
        predict();
        drain();
        if (glog.size() > 0)
            check("abort_dptr_kept", 64'({glog[0].is_d, 8'(glog[0].core)}), 64'({1'b1, 8'd0}));
        check("abort_grants", 64'(glog.size()), 64'd2);

        // Reset asserted while a write is being served.
        do_reset();
        busy_cfg = 0;
        tick();
        bus.dWEN[0] = 1'b1; bus.daddr[0] = 32'h700; bus.dstore[0] = 32'h1234_5678;
        predict();
        drain();
        busy_cfg = 5;
        tick();
        bus.dWEN[1] = 1'b1; bus.daddr[1] = 32'h704; bus.dstore[1] = 32'h8765_4321;
        predict();
        step();
        check("rst_mid_pre_ramWEN", 64'(bus.ramWEN), 64'd1);
        #2;
        nRST = 1'b0;
        #1;
        check("rst_mid_ramWEN", 64'(bus.ramWEN), 64'd0);
        check("rst_mid_ramaddr", 64'(bus.ramaddr), 64'd0);
        check("rst_mid_ramstore", 64'(bus.ramstore), 64'd0);
        do_reset();
        busy_cfg = 0;
        tick();
        bus.dREN = 2'b11; bus.daddr[0] = 32'h900; bus.daddr[1] = 32'h904;
        predict();
        drain();
        if (glog.size() > 0)
            check("rst_mid_dptr_cleared", 64'({glog[0].is_d, 8'(glog[0].core)}), 64'({1'b1, 8'd0}));

        // Both cores fetch instructions only, six transactions.
        do_reset();
        busy_cfg = 0;
        tick();
        mode = 3;
        i_issued = 0;
        apply_policy();
        predict();
        for (int n = 0; n < 100 && glog.size() < 6; n++) step();
        drain();
        check("ii_grants", 64'(glog.size()), 64'd6);
        for (int k = 0; k < glog.size() && k < 6; k++)
            check($sformatf("ii_g%0d", k), 64'({glog[k].is_d, 8'(glog[k].core)}), 64'({1'b0, 8'(k % 2)}));

        // Random traffic with random RAM latency.
        do_reset();
        busy_cfg = -1;
        mode = 1;
        repeat (1500) step();
        drain();

        finish_sim();
    end
endmodule
